alu_op_issuer: RTL and testbench

ALU_OP_ISSUER -- requirements
Module: alu_op_issuer

---
 rtl/alu_op_issuer.sv | 141 ++++++++++++++
 tb/tb_alu_op_issuer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
// rtl/alu_op_issuer.sv - sequences one ALU command through issue, flag capture and response handshake
// Operands stay registered after a command so the parked pass-A op preserves carry for the next command.
module alu_op_issuer #(
    parameter logic [4:0] PARK_OP = 5'b10000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [4:0]  i_cmd_op,
    input  logic [15:0] i_cmd_a,
    input  logic [15:0] i_cmd_b,
    input  logic [2:0]  i_cmd_cond,
    input  logic        i_cmd_wf,
    output logic [15:0] o_alu_a,
    output logic [15:0] o_alu_b,
    output logic [4:0]  o_alu_fun_sel,
    output logic        o_alu_wf,
    input  logic [15:0] i_alu_out,
    input  logic [3:0]  i_alu_flags,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [15:0] o_rsp_data,
    output logic [3:0]  o_rsp_flags,
    output logic        o_rsp_cond_true
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_FLAG  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;

    logic [4:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [2:0]  r_cond;
    logic        r_wf;
    logic [15:0] r_rsp_data;
    logic [3:0]  r_rsp_flags;
    logic        r_rsp_cond_true;

    // Flag bit order is {Z,C,N,O} at [3:0].
    function automatic logic cond_eval(input logic [2:0] cond, input logic [3:0] flags);
        logic res;
        case (cond)
            3'b000:  res = 1'b1;
            3'b001:  res = flags[3];
            3'b010:  res = ~flags[3];
            3'b011:  res = flags[2];
            3'b100:  res = ~flags[2];
            3'b101:  res = flags[1];
            3'b110:  res = flags[0];
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    assign w_accept = i_cmd_valid & (r_state == S_IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        o_cmd_ready     = 1'b0;
        o_rsp_valid     = 1'b0;
        o_alu_fun_sel   = PARK_OP;
        o_alu_wf        = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_alu_fun_sel = r_op;
                o_alu_wf      = r_wf;
                w_next        = S_FLAG;
            end
            S_FLAG: begin
                o_alu_fun_sel = r_op;
                w_next        = S_RESP;
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op            <= 5'd0;
            r_a             <= 16'h0000;
            r_b             <= 16'h0000;
            r_cond          <= 3'd0;
            r_wf            <= 1'b0;
            r_rsp_data      <= 16'h0000;
            r_rsp_flags     <= 4'b0000;
            r_rsp_cond_true <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op   <= i_cmd_op;
                r_a    <= i_cmd_a;
                r_b    <= i_cmd_b;
                r_cond <= i_cmd_cond;
                r_wf   <= i_cmd_wf;
            end
            if (r_state == S_ISSUE) begin
                r_rsp_data <= i_alu_out;
            end
            // Flags are registered inside the ALU, so they only reflect this command one cycle after issue.
            if (r_state == S_FLAG) begin
                r_rsp_flags     <= i_alu_flags;
                r_rsp_cond_true <= cond_eval(r_cond, i_alu_flags);
            end
        end
    end

    assign o_alu_a         = r_a;
    assign o_alu_b         = r_b;
    assign o_rsp_data      = r_rsp_data;
    assign o_rsp_flags     = r_rsp_flags;
    assign o_rsp_cond_true = r_rsp_cond_true;

endmodule

// File: tb/tb_alu_op_issuer.sv
// tb/tb_alu_op_issuer.sv - directed and random checks of alu_op_issuer against a transaction-level model
// The bench owns a behavioural ALU with registered flags that the issuer drives.
module tb_alu_op_issuer;

    localparam logic [4:0] PARK = 5'b10000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [4:0]  cmd_op = 5'd0;
    logic [15:0] cmd_a = 16'h0;
    logic [15:0] cmd_b = 16'h0;
    logic [2:0]  cmd_cond = 3'd0;
    logic        cmd_wf = 1'b0;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [4:0]  alu_fun_sel;
    logic        alu_wf;
    logic [15:0] alu_out;
    logic [3:0]  alu_flags = 4'b0000;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic        rsp_cond_true;

    int errors = 0;
    int checks = 0;
    logic [3:0] ref_flags = 4'b0000;

    always #5 clk = ~clk;

    alu_op_issuer #(.PARK_OP(PARK)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_op(cmd_op), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b),
        .i_cmd_cond(cmd_cond), .i_cmd_wf(cmd_wf),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_fun_sel(alu_fun_sel), .o_alu_wf(alu_wf),
        .i_alu_out(alu_out), .i_alu_flags(alu_flags),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_rsp_flags(rsp_flags), .o_rsp_cond_true(rsp_cond_true)
    );

    // Returns {Z,C,N,O,result}.
    function automatic logic [19:0] alu_fn(input logic [4:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [3:0] fl);
        logic [16:0] s;
        logic [15:0] r;
        logic        c;
        logic        o;
        c = fl[2];
        o = fl[0];
        case (op)
            5'b10000: r = a;
            5'b10100, 5'b10101: begin
                s = {1'b0, a} + {1'b0, b} + ((op == 5'b10101) ? {16'd0, fl[2]} : 17'd0);
                r = s[15:0];
                c = s[16];
                o = (a[15] == b[15]) && (r[15] != a[15]);
            end
            5'b10111: begin r = a & b; c = 1'b0; o = 1'b0; end
            5'b11011: begin r = {a[14:0], 1'b0}; c = a[15]; o = 1'b0; end
            default:  begin r = a ^ b; end
        endcase
        return {(r == 16'h0), c, r[15], o, r};
    endfunction

    function automatic logic cond_ref(input logic [2:0] cond, input logic [3:0] f);
        logic z, c, n, o;
        {z, c, n, o} = f;
        if (cond == 3'd0) return 1'b1;
        if (cond == 3'd1) return z;
        if (cond == 3'd2) return !z;
        if (cond == 3'd3) return c;
        if (cond == 3'd4) return !c;
        if (cond == 3'd5) return n;
        if (cond == 3'd6) return o;
        return 1'b0;
    endfunction

    logic [19:0] alu_res;
    always_comb alu_res = alu_fn(alu_fun_sel, alu_a, alu_b, alu_flags);
    assign alu_out = alu_res[15:0];
    always_ff @(posedge clk) if (alu_wf) alu_flags <= alu_res[19:16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {16'd0, rsp_data}, 32'h0);
        chk("rst_rsp_flags", {28'd0, rsp_flags}, 32'h0);
        chk("rst_rsp_cond", {31'd0, rsp_cond_true}, 32'd0);
        chk("rst_alu_a", {16'd0, alu_a}, 32'h0);
        chk("rst_alu_b", {16'd0, alu_b}, 32'h0);
        chk("rst_fun_sel", {27'd0, alu_fun_sel}, {27'd0, PARK});
        chk("rst_alu_wf", {31'd0, alu_wf}, 32'd0);
    endtask

    // Runs one command end to end; CmdValid stays high with junk after accept to prove it is ignored.
    task automatic run_cmd(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] cond, input logic wf, input int stall);
        logic [19:0] res;
        logic [15:0] exp_data;
        logic [3:0]  exp_flags;
        logic        exp_cond;
        res = alu_fn(op, a, b, ref_flags);
        exp_data = res[15:0];
        if (wf) ref_flags = res[19:16];
        exp_flags = ref_flags;
        exp_cond = cond_ref(cond, exp_flags);

        chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_cond = cond; cmd_wf = wf;
        tick();
        cmd_op = 5'($urandom); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
        cmd_cond = 3'($urandom); cmd_wf = 1'($urandom);
        rsp_ready = (stall == 0);
        chk("issue_ready", {31'd0, cmd_ready}, 32'd0);
        chk("issue_valid", {31'd0, rsp_valid}, 32'd0);
        chk("issue_fun", {27'd0, alu_fun_sel}, {27'd0, op});
        chk("issue_a", {16'd0, alu_a}, {16'd0, a});
        chk("issue_b", {16'd0, alu_b}, {16'd0, b});
        chk("issue_wf", {31'd0, alu_wf}, {31'd0, wf});
        tick();
        chk("flag_valid", {31'd0, rsp_valid}, 32'd0);
        chk("flag_fun", {27'd0, alu_fun_sel}, {27'd0, op});
        chk("flag_wf", {31'd0, alu_wf}, 32'd0);
        tick();
        for (int i = 0; i <= stall; i++) begin
            chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("resp_ready", {31'd0, cmd_ready}, 32'd0);
            chk("resp_data", {16'd0, rsp_data}, {16'd0, exp_data});
            chk("resp_flags", {28'd0, rsp_flags}, {28'd0, exp_flags});
            chk("resp_cond", {31'd0, rsp_cond_true}, {31'd0, exp_cond});
            chk("resp_park", {27'd0, alu_fun_sel}, {27'd0, PARK});
            chk("resp_wf", {31'd0, alu_wf}, 32'd0);
            chk("resp_hold_a", {16'd0, alu_a}, {16'd0, a});
            if (i == stall) rsp_ready = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("done_valid", {31'd0, rsp_valid}, 32'd0);
        chk("done_ready", {31'd0, cmd_ready}, 32'd1);
        chk("done_data_held", {16'd0, rsp_data}, {16'd0, exp_data});
        chk("done_flags_held", {28'd0, rsp_flags}, {28'd0, exp_flags});
    endtask

    initial begin
        logic [4:0] ops [6];
        ops[0] = 5'b10000; ops[1] = 5'b10100; ops[2] = 5'b10101;
        ops[3] = 5'b10111; ops[4] = 5'b11011; ops[5] = 5'b00110;

        #1;
        chk_reset_outputs();
        #13;
        rst = 1'b0;

        run_cmd(5'b10100, 16'h7FFF, 16'h0001, 3'b110, 1'b1, 0);
        chk("add_flags_lit", {28'd0, rsp_flags}, 32'h3);
        run_cmd(5'b10111, 16'h00F0, 16'h0F00, 3'b001, 1'b1, 0);
        chk("and_cond_z", {31'd0, rsp_cond_true}, 32'd1);
        run_cmd(5'b10111, 16'h00F0, 16'h0F00, 3'b111, 1'b1, 0);
        chk("and_cond_never", {31'd0, rsp_cond_true}, 32'd0);
        run_cmd(5'b11011, 16'h8001, 16'h0000, 3'b011, 1'b1, 2);
        chk("lsl_data_lit", {16'd0, rsp_data}, 32'h0002);
        run_cmd(5'b10101, 16'h0001, 16'h0001, 3'b000, 1'b1, 0);
        chk("adc_data_lit", {16'd0, rsp_data}, 32'h0003);
        run_cmd(5'b10100, 16'h1234, 16'h4321, 3'b010, 1'b0, 5);

        for (int c = 0; c < 10; c++) begin
            rsp_ready = 1'b1;
            chk("idle_park", {27'd0, alu_fun_sel}, {27'd0, PARK});
            chk("idle_wf", {31'd0, alu_wf}, 32'd0);
            chk("idle_valid", {31'd0, rsp_valid}, 32'd0);
            tick();
        end
        rsp_ready = 1'b0;

        // Abort during FLAG: flags were already written by the ALU at the issue edge.
        cmd_valid = 1'b1; cmd_op = 5'b10100; cmd_a = 16'hFFFF; cmd_b = 16'h0002;
        cmd_cond = 3'b000; cmd_wf = 1'b1;
        begin
            logic [19:0] r;
            r = alu_fn(5'b10100, 16'hFFFF, 16'h0002, ref_flags);
            ref_flags = r[19:16];
        end
        tick();
        cmd_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        tick();
        chk_reset_outputs();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("post_abort_valid", {31'd0, rsp_valid}, 32'd0);
            tick();
        end

        for (int n = 0; n < 24; n++) begin
            run_cmd(ops[$urandom_range(0, 5)], 16'($urandom), 16'($urandom),
                    3'($urandom), 1'($urandom), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
